game_controller: RTL and testbench

GAME_CONTROLLER -- requirements
Module: game_controller

---
 rtl/game_controller.sv | 150 +++++++++++++++
 tb/tb_game_controller.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/game_controller.sv
// Lane-based game controller: tracks score and lives across LANES play lanes and issues
// per-lane restart requests. Optional high-score tracking is compiled in when
// GAME_CONTROLLER_HIGH_SCORE_EN is defined.
module game_controller #(
  parameter int unsigned LANES   = 3,
  parameter int unsigned SCORE_W = 8,
  parameter int unsigned LIVES   = 3
) (
  input  logic               clock,
  input  logic               reset_button,
  input  logic               start_button,
  input  logic [LANES-1:0]   correct,
  input  logic [LANES-1:0]   game_over,
  output logic [LANES-1:0]   reset_signal,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         lives,
`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
  output logic [SCORE_W-1:0] high_score,
`endif
  output logic [2:0]         state
);

  localparam int unsigned LaneW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [3:0] LivesInit = 4'(LIVES);

  typedef enum logic [2:0] {
    StStart    = 3'd0,
    StRunning  = 3'd1,
    StPoint    = 3'd2,
    StLoseLife = 3'd3,
    StGameOver = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         lives_q, lives_d;
  logic [LANES-1:0]   rs_q, rs_d;
  logic [LANES-1:0]   miss_mask_q, miss_mask_d;
  logic [LaneW-1:0]   lane_q, lane_d;
  logic               hit;
  logic [LaneW-1:0]   hit_lane;

  // Priority-select the lowest-index lane with a correct answer.
  always_comb begin
    hit      = 1'b0;
    hit_lane = '0;
    for (int i = int'(LANES) - 1; i >= 0; i--) begin
      if (correct[i]) begin
        hit      = 1'b1;
        hit_lane = LaneW'(i);
      end
    end
  end

  // Next-state logic; inputs are only acted upon while running.
  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    lives_d     = lives_q;
    lane_d      = lane_q;
    miss_mask_d = miss_mask_q;
    case (state_q)
      StStart: state_d = StRunning;
      StRunning: begin
        // A miss takes precedence over any simultaneous correct answer.
        if (|game_over) begin
          lives_d     = lives_q - 4'd1;
          miss_mask_d = game_over;
          state_d     = (lives_q <= 4'd1) ? StGameOver : StLoseLife;
        end else if (hit) begin
          lane_d  = hit_lane;
          score_d = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
          state_d = StPoint;
        end
      end
      StPoint, StLoseLife: state_d = StRunning;
      StGameOver: begin
        if (start_button) begin
          state_d = StStart;
          score_d = '0;
          lives_d = LivesInit;
        end
      end
      default: begin
        state_d = StStart;
        score_d = '0;
        lives_d = LivesInit;
      end
    endcase
  end

  // Restart requests are decoded from the next state so they register alongside it.
  always_comb begin
    rs_d = '0;
    case (state_d)
      StStart, StGameOver: rs_d = '1;
      StPoint:             rs_d = LANES'(1) << lane_d;
      StLoseLife:          rs_d = miss_mask_d;
      default:             rs_d = '0;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset_button) begin
      state_q     <= StStart;
      score_q     <= '0;
      lives_q     <= LivesInit;
      rs_q        <= '1;
      lane_q      <= '0;
      miss_mask_q <= '0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      rs_q        <= rs_d;
      lane_q      <= lane_d;
      miss_mask_q <= miss_mask_d;
    end
  end

`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
  logic [SCORE_W-1:0] hs_q, hs_d;

  // Capture the final score on the edge that ends a game; survives START.
  always_comb begin
    hs_d = hs_q;
    if (state_d == StGameOver && state_q != StGameOver && score_q > hs_q) begin
      hs_d = score_q;
    end
  end

  // High-score register, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset_button) begin
      hs_q <= '0;
    end else begin
      hs_q <= hs_d;
    end
  end

  assign high_score = hs_q;
`endif

  assign state        = state_q;
  assign score        = score_q;
  assign lives        = lives_q;
  assign reset_signal = rs_q;

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller: dut_a uses default parameters, dut_b uses
// SCORE_W=4 and LIVES=1 for saturation and single-life scenarios.
module tb_game_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rb_a = 1'b0, sb_a = 1'b0, rb_b = 1'b0, sb_b = 1'b0;
  logic [2:0] corr_a = '0, go_a = '0, corr_b = '0, go_b = '0;
  logic [2:0] rs_a, rs_b, st_a, st_b;
  logic [7:0] sc_a;
  logic [3:0] sc_b, lv_a, lv_b;
  logic [7:0] hs_a;
  logic [3:0] hs_b;

  game_controller #(.LANES(3), .SCORE_W(8), .LIVES(3)) dut_a (
    .clock(clk), .reset_button(rb_a), .start_button(sb_a), .correct(corr_a),
    .game_over(go_a), .reset_signal(rs_a), .score(sc_a), .lives(lv_a),
`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
    .high_score(hs_a),
`endif
    .state(st_a)
  );

  game_controller #(.LANES(3), .SCORE_W(4), .LIVES(1)) dut_b (
    .clock(clk), .reset_button(rb_b), .start_button(sb_b), .correct(corr_b),
    .game_over(go_b), .reset_signal(rs_b), .score(sc_b), .lives(lv_b),
`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
    .high_score(hs_b),
`endif
    .state(st_b)
  );

`ifndef GAME_CONTROLLER_HIGH_SCORE_EN
  assign hs_a = '0;
  assign hs_b = '0;
`endif

  typedef struct {
    bit         sel;
    logic [2:0] st;
    logic [2:0] rs;
    logic [7:0] sc;
    logic [3:0] lv;
    logic [7:0] hs;
    string      name;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Drive one cycle of stimulus on the selected DUT; queue the state expected after the edge.
  task automatic step(input bit sel, input logic rb, input logic sb, input logic [2:0] corr,
                      input logic [2:0] go, input logic [2:0] st, input logic [2:0] rs,
                      input int sc, input int lv, input int hs, input string name);
    exp_t e;
    @(negedge clk);
    if (!sel) begin
      rb_a = rb; sb_a = sb; corr_a = corr; go_a = go;
      rb_b = 1'b0; sb_b = 1'b0; corr_b = '0; go_b = '0;
    end else begin
      rb_b = rb; sb_b = sb; corr_b = corr; go_b = go;
      rb_a = 1'b0; sb_a = 1'b0; corr_a = '0; go_a = '0;
    end
    @(posedge clk);
    e.sel = sel; e.st = st; e.rs = rs; e.sc = 8'(sc); e.lv = 4'(lv); e.hs = 8'(hs);
    e.name = name;
    q.push_back(e);
  endtask

  // Monitor: compare registered outputs half a cycle after each edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [2:0] st, rs;
      logic [7:0] sc, hs;
      logic [3:0] lv;
      bit bad;
      e = q.pop_front();
      if (!e.sel) begin
        st = st_a; rs = rs_a; sc = sc_a; lv = lv_a; hs = hs_a;
      end else begin
        st = st_b; rs = rs_b; sc = {4'b0, sc_b}; lv = lv_b; hs = {4'b0, hs_b};
      end
      bad = (st !== e.st) || (rs !== e.rs) || (sc !== e.sc) || (lv !== e.lv);
`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
      bad = bad || (hs !== e.hs);
`endif
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL %s: got st=%0d rs=%b sc=%0d lv=%0d hs=%0d, want st=%0d rs=%b sc=%0d lv=%0d hs=%0d",
                 e.name, st, rs, sc, lv, hs, e.st, e.rs, e.sc, e.lv, e.hs);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    // ---- dut_a: default parameters ----
    step(0, 1, 0, 3'b000, 3'b000, 0, 3'b111, 0, 3, 0, "a_reset");
    step(0, 1, 0, 3'b000, 3'b000, 0, 3'b111, 0, 3, 0, "a_reset_held");
    step(0, 0, 0, 3'b000, 3'b000, 1, 3'b000, 0, 3, 0, "a_start_to_run");
    step(0, 0, 0, 3'b000, 3'b000, 1, 3'b000, 0, 3, 0, "a_idle");
    step(0, 0, 0, 3'b110, 3'b000, 2, 3'b010, 1, 3, 0, "a_point_110");
    step(0, 0, 0, 3'b000, 3'b000, 1, 3'b000, 1, 3, 0, "a_point_ret");
    step(0, 0, 0, 3'b001, 3'b100, 3, 3'b100, 1, 2, 0, "a_miss_wins");
    step(0, 0, 0, 3'b000, 3'b000, 1, 3'b000, 1, 2, 0, "a_lose_ret");
    step(0, 0, 0, 3'b100, 3'b000, 2, 3'b100, 2, 2, 0, "a_point_100");
    step(0, 0, 0, 3'b011, 3'b000, 1, 3'b000, 2, 2, 0, "a_ignore_in_point");
    step(0, 0, 0, 3'b000, 3'b011, 3, 3'b011, 2, 1, 0, "a_miss_011");
    step(0, 0, 0, 3'b000, 3'b111, 1, 3'b000, 2, 1, 0, "a_ignore_in_lose");
    step(0, 0, 0, 3'b000, 3'b010, 4, 3'b111, 2, 0, 2, "a_game_over");
    step(0, 0, 0, 3'b111, 3'b000, 4, 3'b111, 2, 0, 2, "a_over_hold");
    step(0, 0, 1, 3'b000, 3'b000, 0, 3'b111, 0, 3, 2, "a_restart");
    step(0, 0, 0, 3'b000, 3'b000, 1, 3'b000, 0, 3, 2, "a_run_again");
    step(0, 0, 0, 3'b001, 3'b000, 2, 3'b001, 1, 3, 2, "a_point_001");
    step(0, 1, 0, 3'b000, 3'b000, 0, 3'b111, 0, 3, 0, "a_reset_in_point");
    step(0, 0, 0, 3'b000, 3'b000, 1, 3'b000, 0, 3, 0, "a_run_after_reset");

    // ---- dut_b: SCORE_W=4, LIVES=1 ----
    step(1, 1, 0, 3'b000, 3'b000, 0, 3'b111, 0, 1, 0, "b_reset");
    step(1, 0, 0, 3'b000, 3'b000, 1, 3'b000, 0, 1, 0, "b_run");
    for (int i = 1; i <= 5; i++) begin
      step(1, 0, 0, 3'b010, 3'b000, 2, 3'b010, i, 1, 0, "b_point5");
      step(1, 0, 0, 3'b000, 3'b000, 1, 3'b000, i, 1, 0, "b_gap5");
    end
    step(1, 0, 0, 3'b000, 3'b001, 4, 3'b111, 5, 0, 5, "b_over_at5");
    step(1, 0, 1, 3'b000, 3'b000, 0, 3'b111, 0, 1, 5, "b_start_keeps_hs");
    step(1, 0, 0, 3'b000, 3'b000, 1, 3'b000, 0, 1, 5, "b_run2");
    for (int i = 1; i <= 16; i++) begin
      s = (i > 15) ? 15 : i;
      step(1, 0, 0, 3'b001, 3'b000, 2, 3'b001, s, 1, 5, "b_point_sat");
      step(1, 0, 0, 3'b000, 3'b000, 1, 3'b000, s, 1, 5, "b_gap_sat");
    end
    step(1, 0, 0, 3'b000, 3'b100, 4, 3'b111, 15, 0, 15, "b_over_at15");
    step(1, 0, 1, 3'b000, 3'b000, 0, 3'b111, 0, 1, 15, "b_start2");
    step(1, 0, 0, 3'b000, 3'b000, 1, 3'b000, 0, 1, 15, "b_run3");
    for (int i = 1; i <= 3; i++) begin
      step(1, 0, 0, 3'b100, 3'b000, 2, 3'b100, i, 1, 15, "b_point3");
      step(1, 0, 0, 3'b000, 3'b000, 1, 3'b000, i, 1, 15, "b_gap3");
    end
    step(1, 0, 0, 3'b000, 3'b010, 4, 3'b111, 3, 0, 15, "b_over_lower");

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
